// File: rtl/sevenseg_scan_rx.sv
// sevenseg_scan_rx
// Receiving end of a multiplexed seven-segment scan bus.
// - Synchronizes the scanning anode/segment lines.
// - Waits for each digit slot to settle, then decodes the glyph back to a hex nibble.
// - Publishes a 16-bit word once all four digits of a frame have been captured.
//
// Parameters
//   STABLE_CYC  : consecutive cycles the synchronized {an,seg} must be unchanged
//                 before a capture (>= 2)
//   TIMEOUT_CYC : cycles without a legal capture before lost asserts
//
// Ports
//   clk     in   system clock, all state on rising edge
//   rst     in   asynchronous active-high reset
//   an      in   [3:0] anode selects, active-low, an[i]=0 selects digit i
//   seg     in   [6:0] segment lines, active-low, seg[0]=a .. seg[6]=g
//   d       out  [15:0] last complete frame, d[4i+3:4i] = digit i
//   valid   out  one-cycle pulse on the cycle d updates
//   seen    out  [3:0] digits captured in the current frame
//   bad_pat out  one-cycle pulse when a settled pattern is not a hex glyph
//   lost    out  level, no legal capture for TIMEOUT_CYC cycles
module sevenseg_scan_rx #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] d,
  output logic        valid,
  output logic [3:0]  seen,
  output logic        bad_pat,
  output logic        lost
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // The synchronized value has already been present for two cycles when the
  // stable counter starts at zero, so capture fires at count STABLE_CYC-2.
  localparam logic [SW-1:0] CAP_AT  = SW'(STABLE_CYC - 2);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

  localparam logic [10:0] BLANK = {4'hF, 7'h7F};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [10:0]   sync1;
  logic [10:0]   sync2;
  logic [10:0]   prev;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_cnt_next;
  logic [TW-1:0] timeout_cnt;
  logic [15:0]   shadow;
  logic [15:0]   shadow_new;
  logic [3:0]    sync_an;
  logic [6:0]    sync_seg;
  logic [6:0]    pattern;
  logic          changed;
  logic          one_hot;
  logic [1:0]    idx;
  logic [3:0]    dig_mask;
  logic          legal;
  logic [3:0]    nibble;
  logic          capture;
  logic          cap_ok;
  logic          cap_bad;
  logic          frame_done;
  logic          timeout_hit;

  // Two-flop synchronizer on the whole bus, plus a one-cycle delayed copy
  // so that any change of the synchronized value can be detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= BLANK;
      sync2 <= BLANK;
      prev  <= BLANK;
    end else begin
      sync1 <= {an, seg};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sync_an  = sync2[10:7];
  assign sync_seg = sync2[6:0];
  assign pattern  = ~sync_seg;
  assign changed  = (sync2 != prev);

  // Exactly one anode low selects a digit; blank or several anodes low do not.
  always_comb begin
    one_hot = 1'b1;
    idx     = 2'd0;
    case (sync_an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  assign dig_mask = 4'b0001 << idx;

  // Glyph decode on the active-high gfedcba pattern.
  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // FSM state and stable counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      stable_cnt <= '0;
    end else begin
      state      <= state_next;
      stable_cnt <= stable_cnt_next;
    end
  end

  // Any change restarts settling regardless of state; HOLD blocks a second
  // capture of the same steady digit.
  always_comb begin
    state_next      = state;
    stable_cnt_next = stable_cnt;
    capture         = 1'b0;
    if (changed) begin
      stable_cnt_next = '0;
      state_next      = one_hot ? SETTLE : IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        SETTLE: begin
          if (stable_cnt == CAP_AT) begin
            capture    = 1'b1;
            state_next = HOLD;
          end else begin
            stable_cnt_next = stable_cnt + SW'(1);
          end
        end
        HOLD: begin
          state_next = HOLD;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign cap_ok     = capture & legal;
  assign cap_bad    = capture & ~legal;
  assign frame_done = cap_ok && ((seen | dig_mask) == 4'hF);

  // Timeout only expires on a cycle without a legal capture, so a capture
  // landing on the last cycle wins.
  assign timeout_hit = !cap_ok && (timeout_cnt == TO_LAST);

  // Shadow with the current digit merged in, so a completing capture can
  // publish all four nibbles on the same edge.
  always_comb begin
    shadow_new = shadow;
    shadow_new[{idx, 2'b00} +: 4] = nibble;
  end

  // Saturating timeout counter, cleared by legal captures only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (cap_ok) begin
      timeout_cnt <= '0;
    end else if (timeout_cnt != TO_MAX) begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  // Frame assembly and status outputs. A timeout forgets the partial frame
  // progress but keeps the shadow nibbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      d       <= '0;
      valid   <= 1'b0;
      seen    <= '0;
      bad_pat <= 1'b0;
      lost    <= 1'b0;
    end else begin
      valid   <= frame_done;
      bad_pat <= cap_bad;
      if (cap_ok) begin
        shadow <= shadow_new;
        lost   <= 1'b0;
        if (frame_done) begin
          d    <= shadow_new;
          seen <= '0;
        end else begin
          seen <= seen | dig_mask;
        end
      end else if (timeout_hit) begin
        lost <= 1'b1;
        seen <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_rx.sv
// tb_sevenseg_scan_rx
// Directed bench for sevenseg_scan_rx. One instance uses the default timeout;
// a second instance on the same inputs uses a short timeout for the lost path.
module tb_sevenseg_scan_rx;

  logic        clk;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] d;
  logic        valid;
  logic [3:0]  seen;
  logic        bad_pat;
  logic        lost;
  logic [15:0] d_to;
  logic        valid_to;
  logic [3:0]  seen_to;
  logic        bad_pat_to;
  logic        lost_to;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int bad_cnt = 0;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          cyc;
    logic [3:0]  seen;
    logic [15:0] d;
    int          nvalid;
  } vec_t;

  vec_t vecs [16];

  sevenseg_scan_rx #(.STABLE_CYC(4), .TIMEOUT_CYC(1000000)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .d(d), .valid(valid),
    .seen(seen), .bad_pat(bad_pat), .lost(lost)
  );

  sevenseg_scan_rx #(.STABLE_CYC(4), .TIMEOUT_CYC(100)) dut_to (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .d(d_to), .valid(valid_to),
    .seen(seen_to), .bad_pat(bad_pat_to), .lost(lost_to)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters for the main instance, sampled away from the rising edge.
  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt++;
    if (bad_pat === 1'b1) bad_cnt++;
  end

  // Drive one scan value and let n rising edges pass; returns on a falling edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int vb;
    int bb;

    // Four frames in varied digit order covering all sixteen glyphs.
    vecs[0]  = '{4'b1110, ~7'h4F, 7, 4'b0001, 16'h0000, 0};
    vecs[1]  = '{4'b1101, ~7'h06, 7, 4'b0011, 16'h0000, 0};
    vecs[2]  = '{4'b1011, ~7'h5B, 7, 4'b0111, 16'h0000, 0};
    vecs[3]  = '{4'b0111, ~7'h66, 7, 4'b0000, 16'h4213, 1};
    vecs[4]  = '{4'b0111, ~7'h7C, 7, 4'b1000, 16'h4213, 0};
    vecs[5]  = '{4'b1011, ~7'h39, 7, 4'b1100, 16'h4213, 0};
    vecs[6]  = '{4'b1101, ~7'h5E, 7, 4'b1110, 16'h4213, 0};
    vecs[7]  = '{4'b1110, ~7'h79, 7, 4'b0000, 16'hBCDE, 1};
    vecs[8]  = '{4'b1101, ~7'h77, 7, 4'b0010, 16'hBCDE, 0};
    vecs[9]  = '{4'b1110, ~7'h71, 7, 4'b0011, 16'hBCDE, 0};
    vecs[10] = '{4'b0111, ~7'h3F, 7, 4'b1011, 16'hBCDE, 0};
    vecs[11] = '{4'b1011, ~7'h6F, 7, 4'b0000, 16'h09AF, 1};
    vecs[12] = '{4'b1110, ~7'h6D, 7, 4'b0001, 16'h09AF, 0};
    vecs[13] = '{4'b1101, ~7'h7D, 7, 4'b0011, 16'h09AF, 0};
    vecs[14] = '{4'b1011, ~7'h07, 7, 4'b0111, 16'h09AF, 0};
    vecs[15] = '{4'b0111, ~7'h7F, 7, 4'b0000, 16'h8765, 1};

    doReset();
    checkOutput("reset d", d, 16'h0000);
    checkOutput("reset valid", {15'd0, valid}, 16'h0000);
    checkOutput("reset seen", {12'd0, seen}, 16'h0000);
    checkOutput("reset bad_pat", {15'd0, bad_pat}, 16'h0000);
    checkOutput("reset lost", {15'd0, lost}, 16'h0000);
    checkOutput("reset lost_to", {15'd0, lost_to}, 16'h0000);

    // Table-driven frame scanning.
    bb = bad_cnt;
    for (int i = 0; i < 16; i++) begin
      vb = valid_cnt;
      applyStimulus(vecs[i].an, vecs[i].seg, vecs[i].cyc);
      checkOutput($sformatf("vec%0d seen", i), {12'd0, seen}, {12'd0, vecs[i].seen});
      checkOutput($sformatf("vec%0d d", i), d, vecs[i].d);
      checkOutput($sformatf("vec%0d valid", i), 16'(valid_cnt - vb), 16'(vecs[i].nvalid));
    end
    checkOutput("table bad_pat count", 16'(bad_cnt - bb), 16'd0);

    // Digit 0 held for a long time is captured once, then the frame completes.
    vb = valid_cnt;
    applyStimulus(4'b1110, ~7'h06, 1000);
    checkOutput("hold seen0", {12'd0, seen}, 16'h0001);
    applyStimulus(4'b1101, ~7'h07, 7);
    checkOutput("hold seen1", {12'd0, seen}, 16'h0003);
    applyStimulus(4'b1011, ~7'h79, 7);
    checkOutput("hold seen2", {12'd0, seen}, 16'h0007);
    checkOutput("hold no early valid", 16'(valid_cnt - vb), 16'd0);
    applyStimulus(4'b0111, ~7'h4F, 7);
    checkOutput("hold seen3", {12'd0, seen}, 16'h0000);
    checkOutput("hold d", d, 16'h3E71);
    checkOutput("hold valid count", 16'(valid_cnt - vb), 16'd1);

    // Short glitches inside a digit slot never capture.
    bb = bad_cnt;
    applyStimulus(4'b1110, ~7'h5B, 1);
    applyStimulus(4'b1110, 7'h7F, 3);
    checkOutput("glitch seen before settle", {12'd0, seen}, 16'h0000);
    applyStimulus(4'b1110, ~7'h5B, 7);
    checkOutput("glitch seen", {12'd0, seen}, 16'h0001);
    checkOutput("glitch bad_pat count", 16'(bad_cnt - bb), 16'd0);
    applyStimulus(4'b1101, ~7'h06, 7);
    applyStimulus(4'b1011, ~7'h66, 7);
    applyStimulus(4'b0111, ~7'h6F, 7);
    checkOutput("glitch d", d, 16'h9412);

    // Several anodes low, then an illegal glyph with exact latency, then glyph 8.
    doReset();
    bb = bad_cnt;
    applyStimulus(4'b0011, ~7'h3F, 10);
    checkOutput("multi-anode seen", {12'd0, seen}, 16'h0000);
    checkOutput("multi-anode bad count", 16'(bad_cnt - bb), 16'd0);
    applyStimulus(4'b1011, 7'h7F, 5);
    checkOutput("bad_pat before latency", {15'd0, bad_pat}, 16'h0000);
    @(negedge clk);
    checkOutput("bad_pat at latency", {15'd0, bad_pat}, 16'h0001);
    @(negedge clk);
    checkOutput("bad_pat one cycle", {15'd0, bad_pat}, 16'h0000);
    checkOutput("bad_pat seen unchanged", {12'd0, seen}, 16'h0000);
    applyStimulus(4'b1011, 7'h00, 7);
    checkOutput("glyph8 seen", {12'd0, seen}, 16'h0004);
    checkOutput("illegal bad count", 16'(bad_cnt - bb), 16'd1);
    applyStimulus(4'b1110, ~7'h39, 7);
    applyStimulus(4'b1101, ~7'h3F, 7);
    applyStimulus(4'b0111, ~7'h07, 7);
    checkOutput("glyph8 d", d, 16'h780C);

    // Timeout on the short-timeout instance.
    doReset();
    applyStimulus(4'b1110, ~7'h06, 7);
    applyStimulus(4'b1101, ~7'h5B, 6);
    checkOutput("to seen at capture", {12'd0, seen_to}, 16'h0003);
    applyStimulus(4'hF, 7'h7F, 99);
    checkOutput("to lost before limit", {15'd0, lost_to}, 16'h0000);
    checkOutput("to seen before limit", {12'd0, seen_to}, 16'h0003);
    @(negedge clk);
    checkOutput("to lost at limit", {15'd0, lost_to}, 16'h0001);
    checkOutput("to seen cleared", {12'd0, seen_to}, 16'h0000);
    repeat (20) @(negedge clk);
    checkOutput("to lost held", {15'd0, lost_to}, 16'h0001);
    applyStimulus(4'b1011, ~7'h06, 7);
    checkOutput("to lost cleared", {15'd0, lost_to}, 16'h0000);
    checkOutput("to seen after recapture", {12'd0, seen_to}, 16'h0004);

    // Asynchronous reset mid-frame discards everything.
    doReset();
    applyStimulus(4'b1110, ~7'h06, 7);
    applyStimulus(4'b1101, ~7'h5B, 7);
    applyStimulus(4'b1011, ~7'h4F, 7);
    applyStimulus(4'b0111, ~7'h66, 7);
    applyStimulus(4'b1110, ~7'h7F, 7);
    applyStimulus(4'b1101, ~7'h7F, 7);
    applyStimulus(4'b1011, ~7'h7F, 7);
    checkOutput("pre-reset d", d, 16'h4321);
    checkOutput("pre-reset seen", {12'd0, seen}, 16'h0007);
    #2;
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    #1;
    checkOutput("async reset d", d, 16'h0000);
    checkOutput("async reset seen", {12'd0, seen}, 16'h0000);
    checkOutput("async reset valid", {15'd0, valid}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vb = valid_cnt;
    applyStimulus(4'b1101, ~7'h06, 7);
    applyStimulus(4'b1011, ~7'h07, 7);
    applyStimulus(4'b0111, ~7'h39, 7);
    checkOutput("rescan seen", {12'd0, seen}, 16'h000E);
    checkOutput("rescan no valid", 16'(valid_cnt - vb), 16'd0);
    checkOutput("rescan d held", d, 16'h0000);
    applyStimulus(4'b1110, ~7'h79, 7);
    checkOutput("rescan valid", 16'(valid_cnt - vb), 16'd1);
    checkOutput("rescan d", d, 16'hC71E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
